branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Consumes the registered branch target produced one cycle after a branch's EX cycle.
- Evaluates the branch condition (beq/bne/beqz/bnez/jump) on operands presented in the EX cycle.
- Issues a redirect to the PC/fetch unit with a valid/ready handshake, then flushes IF/ID for a fixed number of cycles.
- Stalls upstream while a branch is in flight and keeps saturating branch/taken statistics.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush is asserted after an accepted redirect (0..15).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- br_valid  input  1  EX stage presents an instruction this cycle
- alu_ctrl  input  4  operation code; branch codes from the shared AluCtrl constants
- rs_data  input  32  first compare operand
- rt_data  input  32  second compare operand (ignored for beqz/bnez/jump)
- branch_addr  input  32  registered target; valid in the cycle after the EX cycle
- redirect_ready  input  1  PC unit accepts the redirect
- redirect_valid  output  1  redirect request
- redirect_pc  output  32  target PC, stable while redirect_valid=1
- flush  output  1  kill IF/ID contents
- stall  output  1  hold EX and upstream stages
- branch_cnt  output  CNT_W  resolved branches, saturating
- taken_cnt  output  CNT_W  taken branches, saturating

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0.
- Asynchronous reset mid-operation aborts any pending redirect or flush immediately.
- Branch set: Beq, Bne, Beqz, Bnez, Jump. Every other alu_ctrl value is ignored and causes no state change.
- Conditions:
  - beq: rs_data==rt_data
  - bne: rs_data!=rt_data
  - beqz: rs_data==0
  - bnez: rs_data!=0
  - jump: always taken
- Compare is full 32-bit; no signed arithmetic is needed.
- IDLE:
  - br_valid=1 with a branch code: register taken, increment branch_cnt (and taken_cnt if taken), go to RESOLVE.
  - stall goes high in the following cycle.
- RESOLVE (one cycle; branch_addr is valid here):
  - taken: redirect_pc<=branch_addr, redirect_valid<=1, go to REDIRECT.
  - not taken: go to IDLE.
- REDIRECT:
  - Hold redirect_valid and redirect_pc until redirect_valid&&redirect_ready.
  - On handshake: redirect_valid<=0; if FLUSH_CYCLES>0, load the counter with FLUSH_CYCLES and go to FLUSH, else go to IDLE.
  - redirect_ready while redirect_valid=0 has no effect.
- FLUSH:
  - flush=1 for exactly FLUSH_CYCLES cycles; the counter decrements each cycle.
  - At count 1, go to IDLE.
- stall=1 in every state other than IDLE.
- br_valid in a non-IDLE state is ignored; upstream is stalled and must re-present.
- Latency:
  - EX cycle T, resolution T+1.
  - redirect_valid is first high at T+2.
  - A not-taken branch frees stall at T+2, so one bubble.
- Counters saturate at all-ones and never wrap. Both increment in the same cycle for a taken branch.

Decomposition:
- AluCtrl branch codes and the state enum (IDLE/RESOLVE/REDIRECT/FLUSH) go in the shared package/include, alongside RegBus and ZeroWord.
- One natural sub-module: branch_cond_eval. It is combinational: alu_ctrl, rs_data, rt_data -> is_branch, taken.
- Counters, FSM and redirect register stay in branch_resolve.

Test Plan:
- Beq, rs=rt=0x0000_1234, branch_addr=0x0000_0200 at T+1, redirect_ready=1:
  - redirect_valid at T+2 with redirect_pc=0x200.
  - flush high for 2 cycles, stall low after.
  - branch_cnt=1, taken_cnt=1.
- Bne, rs=rt=5:
  - no redirect, no flush.
  - stall high for exactly 1 cycle.
  - branch_cnt=1, taken_cnt=0.
- Jump with redirect_ready held 0 for 3 cycles:
  - redirect_pc=branch_addr stays stable over those 3 cycles.
  - flush starts only after ready=1.
  - br_valid pulses during the wait are ignored.
- Beqz rs=0 then Bnez rs=0 back-to-back:
  - first is taken, the second is ignored while stall=1.
  - after re-present in IDLE, the second resolves not taken.
  - taken_cnt=1, branch_cnt=2.
- Assert rst during REDIRECT and during FLUSH: all outputs go 0 immediately, state returns to IDLE, counters clear.
- Counter limits and parameter corner:
  - With CNT_W=4, 20 taken jumps leave taken_cnt=15 (saturated).
  - With FLUSH_CYCLES=0, flush never asserts and IDLE returns the cycle after the handshake.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// rtl/branch_resolve_pkg.sv - shared branch codes, FSM states and bus types
// Purpose: constants shared by the branch resolution unit and its condition
//          evaluator.
// Contents: RegBus/ZeroWord data types, AluCtrl branch codes,
//           FSM state encodings.
package branch_resolve_pkg;

  typedef logic [31:0] RegBus;
  localparam RegBus ZeroWord = 32'h0000_0000;

  // AluCtrl operation codes. Only the branch group is acted on here.
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_BEQ  = 4'h8;
  localparam logic [3:0] ALU_BNE  = 4'h9;
  localparam logic [3:0] ALU_BEQZ = 4'hA;
  localparam logic [3:0] ALU_BNEZ = 4'hB;
  localparam logic [3:0] ALU_JUMP = 4'hC;

  // Resolution FSM states.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RESOLVE  = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;
  localparam logic [1:0] ST_FLUSH    = 2'd3;

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational branch condition evaluator
// Purpose: classify alu_ctrl as a branch and decide whether it is taken.
// Ports:
//   alu_ctrl  in  4   operation code
//   rs_data   in  32  first compare operand
//   rt_data   in  32  second compare operand (beq/bne only)
//   is_branch out 1   alu_ctrl is one of beq/bne/beqz/bnez/jump
//   taken     out 1   branch condition holds (0 for non-branches)
module branch_cond_eval
  import branch_resolve_pkg::*;
(
  input  logic [3:0]  alu_ctrl,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        is_branch,
  output logic        taken
);

  logic rs_eq_rt;
  logic rs_zero;

  assign rs_eq_rt = (rs_data == rt_data);
  assign rs_zero  = (rs_data == ZeroWord);

  always_comb begin
    is_branch = 1'b1;
    taken     = 1'b0;
    case (alu_ctrl)
      ALU_BEQ:  taken = rs_eq_rt;
      ALU_BNE:  taken = !rs_eq_rt;
      ALU_BEQZ: taken = rs_zero;
      ALU_BNEZ: taken = !rs_zero;
      ALU_JUMP: taken = 1'b1;
      default:  is_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - branch resolution, redirect handshake and flush control
// Purpose: evaluate a branch in EX, redirect fetch to the registered target,
//          flush IF/ID afterwards, stall upstream while busy, count branches.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   br_valid, alu_ctrl        EX stage instruction and its operation code
//   rs_data, rt_data          compare operands (EX cycle)
//   branch_addr               registered target, valid one cycle after EX
//   redirect_valid/ready/pc   redirect handshake to the PC unit
//   flush                     kill IF/ID contents
//   stall                     hold EX and upstream stages
//   branch_cnt, taken_cnt     saturating statistics
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  input  logic [3:0]       alu_ctrl,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic [31:0]      branch_addr,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             stall,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  logic [1:0]       state_q, state_d;
  logic             taken_q, taken_d;
  logic             redirect_valid_q, redirect_valid_d;
  RegBus            redirect_pc_q, redirect_pc_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic is_branch;
  logic cond_taken;

  branch_cond_eval u_cond (
    .alu_ctrl  (alu_ctrl),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .is_branch (is_branch),
    .taken     (cond_taken)
  );

  always_comb begin
    state_d          = state_q;
    taken_d          = taken_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    flush_cnt_d      = flush_cnt_q;
    branch_cnt_d     = branch_cnt_q;
    taken_cnt_d      = taken_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (br_valid && is_branch) begin
          taken_d = cond_taken;
          state_d = ST_RESOLVE;
          if (!(&branch_cnt_q)) branch_cnt_d = branch_cnt_q + CNT_W'(1);
          if (cond_taken && !(&taken_cnt_q)) taken_cnt_d = taken_cnt_q + CNT_W'(1);
        end
      end
      ST_RESOLVE: begin
        // branch_addr is only meaningful in this cycle, so capture it here.
        if (taken_q) begin
          redirect_pc_d    = branch_addr;
          redirect_valid_d = 1'b1;
          state_d          = ST_REDIRECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        if (redirect_valid_q && redirect_ready) begin
          redirect_valid_d = 1'b0;
          if (FLUSH_CYCLES > 0) begin
            flush_cnt_d = 4'(FLUSH_CYCLES);
            state_d     = ST_FLUSH;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        flush_cnt_d = flush_cnt_q - 4'd1;
        if (flush_cnt_q == 4'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      taken_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= ZeroWord;
      flush_cnt_q      <= 4'd0;
      branch_cnt_q     <= '0;
      taken_cnt_q      <= '0;
    end else begin
      state_q          <= state_d;
      taken_q          <= taken_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_cnt_q      <= flush_cnt_d;
      branch_cnt_q     <= branch_cnt_d;
      taken_cnt_q      <= taken_cnt_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = (state_q == ST_FLUSH);
  assign stall          = (state_q != ST_IDLE);
  assign branch_cnt     = branch_cnt_q;
  assign taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed self-checking bench for branch_resolve
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        br_valid = 1'b0;
  logic [3:0]  alu_ctrl = 4'h0;
  logic [31:0] rs_data = 32'h0;
  logic [31:0] rt_data = 32'h0;
  logic [31:0] branch_addr = 32'h0;
  logic        redirect_ready = 1'b0;

  logic        redirect_valid, s_redirect_valid;
  logic [31:0] redirect_pc, s_redirect_pc;
  logic        flush, s_flush, stall, s_stall;
  logic [15:0] branch_cnt, taken_cnt;
  logic [3:0]  s_branch_cnt, s_taken_cnt;

  int errors = 0;
  int checks = 0;

  branch_resolve u_dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .alu_ctrl(alu_ctrl),
    .rs_data(rs_data), .rt_data(rt_data), .branch_addr(branch_addr),
    .redirect_ready(redirect_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .stall(stall),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  branch_resolve #(.FLUSH_CYCLES(0), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .br_valid(br_valid), .alu_ctrl(alu_ctrl),
    .rs_data(rs_data), .rt_data(rt_data), .branch_addr(branch_addr),
    .redirect_ready(redirect_ready), .redirect_valid(s_redirect_valid),
    .redirect_pc(s_redirect_pc), .flush(s_flush), .stall(s_stall),
    .branch_cnt(s_branch_cnt), .taken_cnt(s_taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    br_valid = 1'b0;
    redirect_ready = 1'b0;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
  endtask

  task automatic present(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    br_valid = 1'b1;
    alu_ctrl = op;
    rs_data  = rs;
    rt_data  = rt;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rv"},    32'(redirect_valid), 32'd0);
    check({tag, "_pc"},    redirect_pc, 32'd0);
    check({tag, "_flush"}, 32'(flush), 32'd0);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_bcnt"},  32'(branch_cnt), 32'd0);
    check({tag, "_tcnt"},  32'(taken_cnt), 32'd0);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    #2;
    check_outputs_zero("reset");
    rst = 1'b0;
    tick();

    // Non-branch op is ignored
    present(ALU_ADD, 32'h1, 32'h1);
    tick();
    br_valid = 1'b0;
    check("nonbr_stall", 32'(stall), 32'd0);
    check("nonbr_bcnt", 32'(branch_cnt), 32'd0);

    // Beq taken, ready=1
    do_reset();
    present(ALU_BEQ, 32'h0000_1234, 32'h0000_1234);
    redirect_ready = 1'b1;
    tick();                                   // T+1
    br_valid = 1'b0;
    branch_addr = 32'h0000_0200;
    check("beq_t1_stall", 32'(stall), 32'd1);
    check("beq_t1_rv", 32'(redirect_valid), 32'd0);
    check("beq_bcnt", 32'(branch_cnt), 32'd1);
    check("beq_tcnt", 32'(taken_cnt), 32'd1);
    tick();                                   // T+2
    branch_addr = 32'hDEAD_BEEF;
    check("beq_t2_rv", 32'(redirect_valid), 32'd1);
    check("beq_t2_pc", redirect_pc, 32'h0000_0200);
    check("beq_t2_flush", 32'(flush), 32'd0);
    tick();                                   // T+3
    check("beq_t3_rv", 32'(redirect_valid), 32'd0);
    check("beq_t3_flush", 32'(flush), 32'd1);
    tick();                                   // T+4
    check("beq_t4_flush", 32'(flush), 32'd1);
    tick();                                   // T+5
    check("beq_t5_flush", 32'(flush), 32'd0);
    check("beq_t5_stall", 32'(stall), 32'd0);

    // Bne not taken
    do_reset();
    present(ALU_BNE, 32'd5, 32'd5);
    tick();
    br_valid = 1'b0;
    check("bne_t1_stall", 32'(stall), 32'd1);
    tick();
    check("bne_t2_stall", 32'(stall), 32'd0);
    check("bne_t2_rv", 32'(redirect_valid), 32'd0);
    check("bne_t2_flush", 32'(flush), 32'd0);
    check("bne_bcnt", 32'(branch_cnt), 32'd1);
    check("bne_tcnt", 32'(taken_cnt), 32'd0);

    // Jump with ready held low for 3 cycles
    do_reset();
    present(ALU_JUMP, 32'h0, 32'h0);
    tick();                                   // T+1
    br_valid = 1'b0;
    branch_addr = 32'h3000_0040;
    tick();                                   // T+2
    for (int i = 0; i < 3; i++) begin
      check("jmp_wait_rv", 32'(redirect_valid), 32'd1);
      check("jmp_wait_pc", redirect_pc, 32'h3000_0040);
      check("jmp_wait_flush", 32'(flush), 32'd0);
      branch_addr = 32'h0BAD_0000 + 32'(i);
      present(ALU_BEQ, 32'h7, 32'h7);
      tick();
    end
    br_valid = 1'b0;
    check("jmp_hold_rv", 32'(redirect_valid), 32'd1);
    check("jmp_hold_pc", redirect_pc, 32'h3000_0040);
    redirect_ready = 1'b1;
    tick();
    check("jmp_f1", 32'(flush), 32'd1);
    tick();
    check("jmp_f2", 32'(flush), 32'd1);
    tick();
    check("jmp_end_flush", 32'(flush), 32'd0);
    check("jmp_end_stall", 32'(stall), 32'd0);
    check("jmp_bcnt", 32'(branch_cnt), 32'd1);
    check("jmp_tcnt", 32'(taken_cnt), 32'd1);

    // Beqz taken then Bnez re-presented until accepted
    do_reset();
    redirect_ready = 1'b1;
    present(ALU_BEQZ, 32'h0, 32'h0);
    tick();                                   // T+1
    present(ALU_BNEZ, 32'h0, 32'h0);
    branch_addr = 32'h0000_0400;
    check("bz_t1_stall", 32'(stall), 32'd1);
    tick();                                   // T+2
    check("bz_t2_pc", redirect_pc, 32'h0000_0400);
    tick();                                   // T+3
    tick();                                   // T+4
    tick();                                   // T+5 IDLE, Bnez accepted here
    check("bz_t5_stall", 32'(stall), 32'd0);
    check("bz_t5_bcnt", 32'(branch_cnt), 32'd1);
    tick();                                   // T+6 RESOLVE
    br_valid = 1'b0;
    check("bnz_bcnt", 32'(branch_cnt), 32'd2);
    check("bnz_tcnt", 32'(taken_cnt), 32'd1);
    tick();                                   // T+7
    check("bnz_stall", 32'(stall), 32'd0);
    check("bnz_rv", 32'(redirect_valid), 32'd0);

    // Async reset during REDIRECT
    do_reset();
    present(ALU_JUMP, 32'h0, 32'h0);
    tick();
    br_valid = 1'b0;
    branch_addr = 32'h0000_0800;
    tick();
    check("rstr_pre_rv", 32'(redirect_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_outputs_zero("rst_redir");
    #2;
    rst = 1'b0;
    tick();
    check("rstr_idle_stall", 32'(stall), 32'd0);

    // Async reset during FLUSH
    redirect_ready = 1'b1;
    present(ALU_JUMP, 32'h0, 32'h0);
    tick();
    br_valid = 1'b0;
    tick();
    tick();
    check("rstf_pre_flush", 32'(flush), 32'd1);
    rst = 1'b1;
    #1;
    check_outputs_zero("rst_flush");
    #2;
    rst = 1'b0;
    tick();
    check("rstf_idle_stall", 32'(stall), 32'd0);

    // FLUSH_CYCLES=0 and CNT_W=4 saturation (u_sat)
    do_reset();
    redirect_ready = 1'b1;
    branch_addr = 32'h0000_1000;
    for (int j = 0; j < 20; j++) begin
      present(ALU_JUMP, 32'h0, 32'h0);
      tick();                                 // RESOLVE
      br_valid = 1'b0;
      tick();                                 // REDIRECT, handshake
      if (j == 0) check("sat_rv", 32'(s_redirect_valid), 32'd1);
      tick();                                 // back in IDLE
      if (j == 0) begin
        check("f0_flush", 32'(s_flush), 32'd0);
        check("f0_stall", 32'(s_stall), 32'd0);
        check("f0_rv", 32'(s_redirect_valid), 32'd0);
      end
      if (j == 14) check("sat_tcnt_15", 32'(s_taken_cnt), 32'd15);
    end
    check("sat_tcnt", 32'(s_taken_cnt), 32'd15);
    check("sat_bcnt", 32'(s_branch_cnt), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
